phy_init_seq: RTL and testbench
===============================

Name: phy_init_seq

Overview:
Power-up sequencer for the Ethernet PHY. It holds the PHY hardware reset low for a fixed time, then waits for the PHY to settle. It then writes a table of PHY configuration registers through a req/ack handshake to the MDIO master, and finally flags init done or init error. It sits between the board reset and the MAC/MDIO logic, and gates MAC enable via init_done.

Parameters:
RST_CYCLES, 255, clocks phy_rst_n held low (1..65535)
WAIT_CYCLES, 1000, clocks between phy_rst_n release and first MDIO write (1..65535)
NUM_REGS, 4, entries in config table (0..2**IDX_W-1)
IDX_W, 4, width of cfg_idx
PHY_ADDR, 5'd1, PHY MDIO address driven on every write
TIMEOUT_CYCLES, 4096, max clocks waiting for mdio_ack per write (1..65535)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
restart  in  1  single-cycle sync request to rerun the full sequence
phy_rst_n  out  1  PHY hardware reset, active low
cfg_idx  out  IDX_W  config table index (external ROM, combinational read)
cfg_reg  in  5  PHY register address for entry cfg_idx
cfg_data  in  16  write data for entry cfg_idx
mdio_req  out  1  write request to MDIO master
mdio_phy  out  5  PHY address (= PHY_ADDR)
mdio_reg  out  5  register address, stable while mdio_req=1
mdio_wdata  out  16  write data, stable while mdio_req=1
mdio_ack  in  1  single-cycle completion strobe from MDIO master
mdio_err  in  1  error qualifier, valid only with mdio_ack
init_done  out  1  sequence completed OK
init_err  out  1  sequence aborted

Behaviour:
- All outputs registered. One 16-bit cycle counter cnt, shared by all states.
- Reset (rst=1, async):
  - state=RST_ASSERT, cnt=0, cfg_idx=0.
  - phy_rst_n=0, mdio_req=0, mdio_reg=0, mdio_wdata=0, init_done=0, init_err=0.
  - mdio_phy=PHY_ADDR constant.
- RST_ASSERT: cnt increments each clock. When cnt==RST_CYCLES-1: phy_rst_n<=1, cnt<=0, go to SETTLE. phy_rst_n is low for exactly RST_CYCLES rising edges after rst deasserts.
- SETTLE: cnt increments each clock. When cnt==WAIT_CYCLES-1: cnt<=0, then:
  - NUM_REGS==0: go to DONE.
  - Otherwise: go to ISSUE.
- ISSUE (1 cycle): capture mdio_reg<=cfg_reg, mdio_wdata<=cfg_data, mdio_req<=1, cnt<=0, go to WAIT_ACK. The first mdio_req rises at edge RST_CYCLES+WAIT_CYCLES+1 after reset release.
- WAIT_ACK: mdio_req, mdio_reg and mdio_wdata are held until an ack is sampled. cnt increments each clock.
  - mdio_ack=1 and mdio_err=0: mdio_req<=0.
    - cfg_idx==NUM_REGS-1: go to DONE.
    - Otherwise: cfg_idx<=cfg_idx+1, go to ISSUE. mdio_req is therefore low for at least 1 cycle between writes.
  - mdio_ack=1 and mdio_err=1: mdio_req<=0, go to FAIL.
  - No ack and cnt==TIMEOUT_CYCLES-1: mdio_req<=0, go to FAIL.
  - An ack arriving on the timeout cycle wins over the timeout.
- DONE: init_done=1, terminal.
- FAIL: init_err=1, init_done=0, terminal. cfg_idx holds the failing entry.
- mdio_ack outside WAIT_ACK is ignored.
- restart=1 in any state: next state RST_ASSERT with all registers set to their reset values, including phy_rst_n=0 and mdio_req=0. restart has priority over mdio_ack and timeout in the same cycle. A restart during WAIT_ACK abandons the write; a late ack afterwards is ignored.
- init_done and init_err are never both 1.
- cnt never wraps: it is cleared on every state change.

Test Plan:
Use RST_CYCLES=4, WAIT_CYCLES=6, NUM_REGS=2, TIMEOUT_CYCLES=8, PHY_ADDR=1 for all scenarios.
- Nominal: release rst; MDIO model acks 3 cycles after each req. Required: phy_rst_n low for exactly 4 edges; first mdio_req at edge 11 with (phy=1, reg, data) of entry 0; second write uses entry 1; init_done=1 one cycle after the second ack; init_err=0.
- Write error: ack with mdio_err=1 on entry 1. Required: mdio_req drops, init_err=1, init_done=0, cfg_idx=1.
- Timeout: never ack. Required: mdio_req high exactly 8 cycles, then init_err=1.
- Restart mid-write: pulse restart during WAIT_ACK of entry 0, with a late ack 2 cycles later. Required: phy_rst_n=0 and mdio_req=0 on the next edge; the late ack is ignored; the full sequence reruns and reaches init_done.
- Async reset: assert rst between clock edges during SETTLE. Required: phy_rst_n=0, init_done=0, mdio_req=0 immediately, without waiting for a clock edge.
- NUM_REGS=0 build: required init_done=1 at edge 11 after reset release, with no mdio_req ever asserted.

Source files
------------

// File: rtl/phy_init_seq.sv
// Ethernet PHY power-up sequencer: holds the PHY in reset, waits for it to settle,
// then writes a configuration table over the MDIO req/ack handshake and flags done or error.
module phy_init_seq #(
  parameter int         RST_CYCLES     = 255,
  parameter int         WAIT_CYCLES    = 1000,
  parameter int         NUM_REGS       = 4,
  parameter int         IDX_W          = 4,
  parameter logic [4:0] PHY_ADDR       = 5'd1,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  output logic             phy_rst_n,
  output logic [IDX_W-1:0] cfg_idx,
  input  logic [4:0]       cfg_reg,
  input  logic [15:0]      cfg_data,
  output logic             mdio_req,
  output logic [4:0]       mdio_phy,
  output logic [4:0]       mdio_reg,
  output logic [15:0]      mdio_wdata,
  input  logic             mdio_ack,
  input  logic             mdio_err,
  output logic             init_done,
  output logic             init_err
);

  typedef enum logic [2:0] {
    S_RST_ASSERT,
    S_SETTLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [15:0]      RST_LAST  = 16'(RST_CYCLES - 1);
  localparam logic [15:0]      WAIT_LAST = 16'(WAIT_CYCLES - 1);
  localparam logic [15:0]      TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'((NUM_REGS > 0) ? (NUM_REGS - 1) : 0);

  state_t           r_state, w_state;
  logic [15:0]      r_cnt, w_cnt;
  logic [IDX_W-1:0] r_idx, w_idx;
  logic             r_phy_rst_n, w_phy_rst_n;
  logic             r_req, w_req;
  logic [4:0]       r_reg, w_reg;
  logic [15:0]      r_wdata, w_wdata;
  logic             r_done, w_done;
  logic             r_err, w_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RST_ASSERT;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_phy_rst_n <= 1'b0;
      r_req       <= 1'b0;
      r_reg       <= '0;
      r_wdata     <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_idx       <= w_idx;
      r_phy_rst_n <= w_phy_rst_n;
      r_req       <= w_req;
      r_reg       <= w_reg;
      r_wdata     <= w_wdata;
      r_done      <= w_done;
      r_err       <= w_err;
    end
  end

  // Status flags follow the terminal state one cycle late, so they can never both be set.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt + 16'd1;
    w_idx       = r_idx;
    w_phy_rst_n = r_phy_rst_n;
    w_req       = r_req;
    w_reg       = r_reg;
    w_wdata     = r_wdata;
    w_done      = 1'b0;
    w_err       = 1'b0;

    case (r_state)
      S_RST_ASSERT: begin
        if (r_cnt == RST_LAST) begin
          w_phy_rst_n = 1'b1;
          w_cnt       = '0;
          w_state     = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == WAIT_LAST) begin
          w_cnt   = '0;
          w_state = (NUM_REGS == 0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_reg   = cfg_reg;
        w_wdata = cfg_data;
        w_req   = 1'b1;
        w_cnt   = '0;
        w_state = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // An ack landing on the timeout cycle is honoured ahead of the timeout.
        if (mdio_ack) begin
          w_req = 1'b0;
          w_cnt = '0;
          if (mdio_err) begin
            w_state = S_FAIL;
          end else if (r_idx == LAST_IDX) begin
            w_state = S_DONE;
          end else begin
            w_idx   = r_idx + 1'b1;
            w_state = S_ISSUE;
          end
        end else if (r_cnt == TO_LAST) begin
          w_req   = 1'b0;
          w_cnt   = '0;
          w_state = S_FAIL;
        end
      end
      S_DONE: begin
        w_cnt  = '0;
        w_done = 1'b1;
      end
      S_FAIL: begin
        w_cnt = '0;
        w_err = 1'b1;
      end
      default: begin
        w_cnt   = '0;
        w_state = S_RST_ASSERT;
      end
    endcase

    if (restart) begin
      w_state     = S_RST_ASSERT;
      w_cnt       = '0;
      w_idx       = '0;
      w_phy_rst_n = 1'b0;
      w_req       = 1'b0;
      w_reg       = '0;
      w_wdata     = '0;
      w_done      = 1'b0;
      w_err       = 1'b0;
    end
  end

  assign phy_rst_n  = r_phy_rst_n;
  assign cfg_idx    = r_idx;
  assign mdio_req   = r_req;
  assign mdio_phy   = PHY_ADDR;
  assign mdio_reg   = r_reg;
  assign mdio_wdata = r_wdata;
  assign init_done  = r_done;
  assign init_err   = r_err;

endmodule

// File: tb/tb_phy_init_seq.sv
// Scoreboard bench for phy_init_seq: expected MDIO writes are queued as each scenario
// starts and popped as the sequencer raises mdio_req; timing and status are checked per scenario.
module tb_phy_init_seq;

  localparam int RST_C = 4;
  localparam int WAIT_C = 6;
  localparam int NREGS = 2;
  localparam int TO_C = 8;

  typedef struct {
    logic [4:0]  phy;
    logic [4:0]  regAddr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic       phyRstN;
    logic       req;
    logic [3:0] idx;
    logic       done;
    logic       err;
  } snap_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, restart, mdio_ack, mdio_err;
  logic        phy_rst_n, mdio_req, init_done, init_err;
  logic [3:0]  cfg_idx;
  logic [4:0]  cfg_reg, mdio_phy, mdio_reg;
  logic [15:0] cfg_data, mdio_wdata;

  logic        rst0;
  logic        phy_rst_n0, mdio_req0, init_done0, init_err0;
  logic [3:0]  cfg_idx0;
  logic [4:0]  mdio_phy0, mdio_reg0;
  logic [15:0] mdio_wdata0;

  logic [4:0]  romReg [16];
  logic [15:0] romData[16];

  assign cfg_reg  = romReg[cfg_idx];
  assign cfg_data = romData[cfg_idx];

  phy_init_seq #(
    .RST_CYCLES(RST_C), .WAIT_CYCLES(WAIT_C), .NUM_REGS(NREGS), .IDX_W(4),
    .PHY_ADDR(5'd1), .TIMEOUT_CYCLES(TO_C)
  ) dut (
    .clk(clk), .rst(rst), .restart(restart), .phy_rst_n(phy_rst_n),
    .cfg_idx(cfg_idx), .cfg_reg(cfg_reg), .cfg_data(cfg_data),
    .mdio_req(mdio_req), .mdio_phy(mdio_phy), .mdio_reg(mdio_reg),
    .mdio_wdata(mdio_wdata), .mdio_ack(mdio_ack), .mdio_err(mdio_err),
    .init_done(init_done), .init_err(init_err)
  );

  phy_init_seq #(
    .RST_CYCLES(RST_C), .WAIT_CYCLES(WAIT_C), .NUM_REGS(0), .IDX_W(4),
    .PHY_ADDR(5'd1), .TIMEOUT_CYCLES(TO_C)
  ) dut0 (
    .clk(clk), .rst(rst0), .restart(1'b0), .phy_rst_n(phy_rst_n0),
    .cfg_idx(cfg_idx0), .cfg_reg(5'h1f), .cfg_data(16'hdead),
    .mdio_req(mdio_req0), .mdio_phy(mdio_phy0), .mdio_reg(mdio_reg0),
    .mdio_wdata(mdio_wdata0), .mdio_ack(1'b0), .mdio_err(1'b0),
    .init_done(init_done0), .init_err(init_err0)
  );

  int    errors = 0;
  int    checks = 0;
  wr_t   expQ[$];
  int    evRise[$];
  int    evRstHigh, evDone, evErr, reqHigh;
  snap_t snap[2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pushEntry(input int i);
    wr_t w;
    w.phy = 5'd1;
    w.regAddr = romReg[i];
    w.data = romData[i];
    expQ.push_back(w);
  endtask

  // Holds reset for two edges and releases it just after an edge, so the next posedge is edge 1.
  task automatic doReset();
    rst = 1'b1;
    restart = 1'b0;
    mdio_ack = 1'b0;
    mdio_err = 1'b0;
    expQ.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  // MDIO master model plus scoreboard; records edge numbers of the events each scenario cares about.
  task automatic runMdio(input int nEdges, input int ackDelay, input int errWrite,
                         input int firstAutoAck, input int restartEdge, input int lateAckEdge,
                         input int snapEdgeA, input int snapEdgeB);
    logic reqPrev;
    int   ackAt, nRise;
    logic ackErr;
    wr_t  ex;
    reqPrev = 1'b0;
    ackAt = -1;
    nRise = 0;
    ackErr = 1'b0;
    evRise.delete();
    evRstHigh = -1;
    evDone = -1;
    evErr = -1;
    reqHigh = 0;
    for (int e = 1; e <= nEdges; e++) begin
      step();
      mdio_ack = 1'b0;
      mdio_err = 1'b0;
      restart = 1'b0;
      if (phy_rst_n && evRstHigh < 0) evRstHigh = e;
      if (init_done && evDone < 0) evDone = e;
      if (init_err && evErr < 0) evErr = e;
      if (mdio_req) reqHigh++;
      if (e == snapEdgeA) snap[0] = '{phy_rst_n, mdio_req, cfg_idx, init_done, init_err};
      if (e == snapEdgeB) snap[1] = '{phy_rst_n, mdio_req, cfg_idx, init_done, init_err};
      if (mdio_req && !reqPrev) begin
        evRise.push_back(e);
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_write edge %0d: got phy=%0d reg=%0d data=%h, required no write",
                   e, mdio_phy, mdio_reg, mdio_wdata);
        end else begin
          ex = expQ.pop_front();
          if (mdio_phy !== ex.phy || mdio_reg !== ex.regAddr || mdio_wdata !== ex.data) begin
            errors++;
            $display("[TB] FAIL write_contents edge %0d: got phy=%0d reg=%0d data=%h, required phy=%0d reg=%0d data=%h",
                     e, mdio_phy, mdio_reg, mdio_wdata, ex.phy, ex.regAddr, ex.data);
          end
        end
        if (ackDelay > 0 && nRise >= firstAutoAck) begin
          ackAt = e + ackDelay;
          ackErr = (nRise == errWrite);
        end
        nRise++;
      end
      reqPrev = mdio_req;
      if (e == ackAt - 1) begin
        mdio_ack = 1'b1;
        mdio_err = ackErr;
      end
      if (e == lateAckEdge - 1) mdio_ack = 1'b1;
      if (e == restartEdge - 1) restart = 1'b1;
    end
    mdio_ack = 1'b0;
    mdio_err = 1'b0;
    restart = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    restart = 1'b0;
    mdio_ack = 1'b0;
    mdio_err = 1'b0;
    step();
    checks++; if (phy_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_phy_rst_n: got %b, required 0", phy_rst_n); end
    checks++; if (mdio_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mdio_req: got %b, required 0", mdio_req); end
    checks++; if (cfg_idx !== 4'd0) begin errors++; $display("[TB] FAIL reset_cfg_idx: got %0d, required 0", cfg_idx); end
    checks++; if (mdio_reg !== 5'd0) begin errors++; $display("[TB] FAIL reset_mdio_reg: got %0d, required 0", mdio_reg); end
    checks++; if (mdio_wdata !== 16'd0) begin errors++; $display("[TB] FAIL reset_mdio_wdata: got %h, required 0000", mdio_wdata); end
    checks++; if (mdio_phy !== 5'd1) begin errors++; $display("[TB] FAIL reset_mdio_phy: got %0d, required 1", mdio_phy); end
    checks++; if (init_done !== 1'b0 || init_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_status: got done=%b err=%b, required 0/0", init_done, init_err); end
  endtask

  task automatic test_nominal();
    doReset();
    pushEntry(0);
    pushEntry(1);
    runMdio(24, 3, -1, 0, -1, -1, -1, -1);
    checks++; if (evRstHigh !== RST_C) begin errors++; $display("[TB] FAIL nominal_phy_rst_low_edges: got %0d, required %0d", evRstHigh, RST_C); end
    checks++; if (evRise.size() !== 2) begin errors++; $display("[TB] FAIL nominal_write_count: got %0d, required 2", evRise.size()); end
    else begin
      checks++; if (evRise[0] !== 11) begin errors++; $display("[TB] FAIL nominal_first_req_edge: got %0d, required 11", evRise[0]); end
      checks++; if (evRise[1] !== 15) begin errors++; $display("[TB] FAIL nominal_second_req_edge: got %0d, required 15", evRise[1]); end
    end
    checks++; if (evDone !== 19) begin errors++; $display("[TB] FAIL nominal_done_edge: got %0d, required 19", evDone); end
    checks++; if (evErr !== -1) begin errors++; $display("[TB] FAIL nominal_no_err: init_err rose at edge %0d, required never", evErr); end
    checks++; if (init_done !== 1'b1 || mdio_req !== 1'b0) begin errors++; $display("[TB] FAIL nominal_final: got done=%b req=%b, required 1/0", init_done, mdio_req); end
  endtask

  task automatic test_write_error();
    doReset();
    pushEntry(0);
    pushEntry(1);
    runMdio(22, 3, 1, 0, -1, -1, 18, -1);
    checks++; if (snap[0].req !== 1'b0) begin errors++; $display("[TB] FAIL werr_req_drop: got req=%b after error ack, required 0", snap[0].req); end
    checks++; if (evErr !== 19) begin errors++; $display("[TB] FAIL werr_err_edge: got %0d, required 19", evErr); end
    checks++; if (evDone !== -1) begin errors++; $display("[TB] FAIL werr_no_done: init_done rose at edge %0d, required never", evDone); end
    checks++; if (cfg_idx !== 4'd1) begin errors++; $display("[TB] FAIL werr_cfg_idx: got %0d, required 1", cfg_idx); end
    checks++; if (init_err !== 1'b1 || init_done !== 1'b0) begin errors++; $display("[TB] FAIL werr_final: got err=%b done=%b, required 1/0", init_err, init_done); end
    checks++; if (expQ.size() !== 0) begin errors++; $display("[TB] FAIL werr_pending_writes: got %0d left, required 0", expQ.size()); end
  endtask

  task automatic test_timeout();
    doReset();
    pushEntry(0);
    runMdio(24, 0, -1, 0, -1, -1, -1, -1);
    checks++; if (reqHigh !== TO_C) begin errors++; $display("[TB] FAIL timeout_req_cycles: got %0d, required %0d", reqHigh, TO_C); end
    checks++; if (evErr !== 20) begin errors++; $display("[TB] FAIL timeout_err_edge: got %0d, required 20", evErr); end
    checks++; if (init_done !== 1'b0 || cfg_idx !== 4'd0) begin errors++; $display("[TB] FAIL timeout_final: got done=%b idx=%0d, required 0/0", init_done, cfg_idx); end
  endtask

  task automatic test_restart();
    doReset();
    pushEntry(0);
    pushEntry(0);
    pushEntry(1);
    runMdio(36, 3, -1, 1, 13, 15, 13, 15);
    checks++; if (snap[0].phyRstN !== 1'b0 || snap[0].req !== 1'b0) begin errors++; $display("[TB] FAIL restart_immediate: got phy_rst_n=%b req=%b, required 0/0", snap[0].phyRstN, snap[0].req); end
    checks++; if (snap[1].phyRstN !== 1'b0 || snap[1].req !== 1'b0 || snap[1].err !== 1'b0 || snap[1].idx !== 4'd0) begin
      errors++; $display("[TB] FAIL restart_late_ack: got phy_rst_n=%b req=%b err=%b idx=%0d, required 0/0/0/0", snap[1].phyRstN, snap[1].req, snap[1].err, snap[1].idx); end
    checks++; if (evRise.size() !== 3) begin errors++; $display("[TB] FAIL restart_write_count: got %0d, required 3", evRise.size()); end
    else begin
      checks++; if (evRise[1] !== 24 || evRise[2] !== 28) begin errors++; $display("[TB] FAIL restart_rerun_edges: got %0d,%0d, required 24,28", evRise[1], evRise[2]); end
    end
    checks++; if (evDone !== 32) begin errors++; $display("[TB] FAIL restart_done_edge: got %0d, required 32", evDone); end
    checks++; if (evErr !== -1) begin errors++; $display("[TB] FAIL restart_no_err: init_err rose at edge %0d, required never", evErr); end
  endtask

  task automatic test_async_reset();
    doReset();
    runMdio(7, 0, -1, 0, -1, -1, -1, -1);
    checks++; if (phy_rst_n !== 1'b1) begin errors++; $display("[TB] FAIL async_settle_precond: got phy_rst_n=%b, required 1", phy_rst_n); end
    #2 rst = 1'b1;
    #1;
    checks++; if (phy_rst_n !== 1'b0 || init_done !== 1'b0 || mdio_req !== 1'b0) begin
      errors++; $display("[TB] FAIL async_settle: got phy_rst_n=%b done=%b req=%b, required 0/0/0", phy_rst_n, init_done, mdio_req); end
    doReset();
    pushEntry(0);
    runMdio(12, 0, -1, 0, -1, -1, -1, -1);
    checks++; if (mdio_req !== 1'b1) begin errors++; $display("[TB] FAIL async_wait_precond: got req=%b, required 1", mdio_req); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mdio_req !== 1'b0 || phy_rst_n !== 1'b0 || mdio_wdata !== 16'd0) begin
      errors++; $display("[TB] FAIL async_wait_ack: got req=%b phy_rst_n=%b wdata=%h, required 0/0/0000", mdio_req, phy_rst_n, mdio_wdata); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_no_regs();
    int   doneEdge;
    logic sawReq;
    doneEdge = -1;
    sawReq = 1'b0;
    rst0 = 1'b1;
    step();
    step();
    rst0 = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      step();
      if (init_done0 && doneEdge < 0) doneEdge = e;
      if (mdio_req0) sawReq = 1'b1;
    end
    checks++; if (doneEdge !== 11) begin errors++; $display("[TB] FAIL noregs_done_edge: got %0d, required 11", doneEdge); end
    checks++; if (sawReq !== 1'b0) begin errors++; $display("[TB] FAIL noregs_no_req: got req seen=%b, required 0", sawReq); end
    checks++; if (init_err0 !== 1'b0 || phy_rst_n0 !== 1'b1) begin errors++; $display("[TB] FAIL noregs_final: got err=%b phy_rst_n=%b, required 0/1", init_err0, phy_rst_n0); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      romReg[i] = 5'(i * 3 + 2);
      romData[i] = 16'(16'h1000 + i * 16'h0111);
    end
    romReg[0] = 5'h00;
    romData[0] = 16'h1140;
    romReg[1] = 5'h04;
    romData[1] = 16'h01e1;
    rst = 1'b1;
    rst0 = 1'b1;
    restart = 1'b0;
    mdio_ack = 1'b0;
    mdio_err = 1'b0;
    test_reset();
    test_nominal();
    test_write_error();
    test_timeout();
    test_restart();
    test_async_reset();
    test_no_regs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
